// File: rtl/dram_host_ctrl.sv
// -----------------------------------------------------------------------------
// dram_host_ctrl
//   Host-side initiator for simple_dram. Takes valid/ready read/write requests,
//   drives the memory's addr/wdata/write_en pins and returns read data after the
//   memory's one-cycle registered read. A free-running counter periodically
//   forces a refresh window during which no requests are accepted.
//
// Optional feature macro: DRAM_CTRL_WR_VERIFY_EN
//   When defined, every write is followed by a read-back of the same address and
//   a compare against the written data; a mismatch sets the sticky wr_err flag.
//   When undefined, wr_err is held 0.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  request handshake (req_ready is combinational)
//   req_we           1=write, 0=read
//   req_addr/wdata   request address / write data
//   rsp_valid        one-cycle pulse, rsp_rdata valid (reads only)
//   rsp_rdata        read data
//   busy             FSM not in IDLE
//   refresh_active   high while in the refresh window
//   wr_err           sticky write-verify mismatch
//   mem_addr/wdata   to simple_dram addr/wdata
//   mem_we           to simple_dram write_en
//   mem_rdata        from simple_dram rdata (registered, 1-cycle latency)
// -----------------------------------------------------------------------------
module dram_host_ctrl #(
    parameter int ADDR_W           = 4,
    parameter int DATA_W           = 8,
    parameter int REFRESH_INTERVAL = 64,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              refresh_active,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(REFRESH_INTERVAL);
    localparam int RC_W  = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);

`ifdef DRAM_CTRL_WR_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, REFRESH, VFY_RD, VFY_CMP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, REFRESH} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [RC_W-1:0]   rcyc_q, rcyc_d;
    logic              pending_q, pending_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              ref_act_q, ref_act_d;
    logic              busy_q, busy_d;
    logic              wr_err_q, wr_err_d;
    logic              wrap;
    logic              enter_ref;

    assign wrap = (ref_cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        rcyc_d      = rcyc_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wr_err_d    = wr_err_q;
        enter_ref   = 1'b0;
        // Counter runs regardless of FSM state so the refresh cadence is fixed.
        ref_cnt_d   = wrap ? '0 : ref_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                // A pending refresh wins over a same-cycle request; req_ready
                // is already low in that case so nothing is dropped.
                if (pending_q) begin
                    state_d   = REFRESH;
                    rcyc_d    = '0;
                    enter_ref = 1'b1;
                end else if (req_valid) begin
                    state_d     = req_we ? WRITE : READ;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                end
            end
            WRITE: begin
`ifdef DRAM_CTRL_WR_VERIFY_EN
                state_d = VFY_RD;
`else
                state_d = IDLE;
`endif
            end
            READ:    state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_rdata;
                state_d     = IDLE;
            end
            REFRESH: begin
                if (rcyc_q == RC_LAST) state_d = IDLE;
                else                   rcyc_d  = rcyc_q + RC_W'(1);
            end
`ifdef DRAM_CTRL_WR_VERIFY_EN
            // Address and data are still held from the write, so the read-back
            // targets the same location and compares against the written value.
            VFY_RD:  state_d = VFY_CMP;
            VFY_CMP: begin
                if (mem_rdata != mem_wdata_q) wr_err_d = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // At most one refresh outstanding: a wrap while pending is absorbed.
        pending_d = (pending_q && !enter_ref) || wrap;
        mem_we_d  = (state_d == WRITE);
        busy_d    = (state_d != IDLE);
        ref_act_d = (state_d == REFRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ref_cnt_q   <= '0;
            rcyc_q      <= '0;
            pending_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ref_act_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            rcyc_q      <= rcyc_d;
            pending_q   <= pending_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ref_act_q   <= ref_act_d;
            busy_q      <= busy_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && !pending_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign busy           = busy_q;
    assign refresh_active = ref_act_q;
    assign wr_err         = wr_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_we         = mem_we_q;

endmodule
